// File: rtl/store_unit_pkg.sv
// Shared types for the store unit: store-size encodings, output FSM states,
// buffered entry layout and the lane/enable helper functions.
package store_unit_pkg;

  typedef enum logic [1:0] {
    OP_SW     = 2'd0,
    OP_SB     = 2'd1,
    OP_SH     = 2'd2,
    OP_SW_ALT = 2'd3
  } store_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // One buffered store, already in memory-port format.
  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } entry_t;

  function automatic entry_t build_entry(input logic [31:0] addr,
                                         input logic [31:0] data,
                                         input store_op_e   op);
    entry_t e;
    e.addr = addr[31:2];
    case (op)
      OP_SB: begin
        e.be   = 4'b0001 << addr[1:0];
        e.data = {4{data[7:0]}};
      end
      OP_SH: begin
        e.be   = addr[1] ? 4'b1100 : 4'b0011;
        e.data = {2{data[15:0]}};
      end
      default: begin
        e.be   = 4'b1111;
        e.data = data;
      end
    endcase
    return e;
  endfunction

  function automatic logic misaligned(input logic [1:0] lsb, input store_op_e op);
    case (op)
      OP_SB:   return 1'b0;
      OP_SH:   return lsb[0];
      default: return lsb != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Circular store buffer: DEPTH entries (power of two), pointers wrap naturally.
// The caller never pushes when full nor pops when empty.
module store_fifo
  import store_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  entry_t        wdata,
  input  logic          pop,
  output entry_t        rdata,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; count alone says which slots hold live stores.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata      = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/store_unit.sv
// Store unit: formats pipeline stores into lane-enabled word writes, buffers
// them in store_fifo and drains them in order through a req/ack memory port.
// Optional macro STORE_ALIGN_EXC_EN rejects misaligned halfword/word stores.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_op,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        empty,
  output logic        adr_exc
);

  localparam int            CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic          push, pop;
  entry_t        in_entry, head;
  logic [CW-1:0] count, count_next;
  state_e        state_q, state_d;
  logic          in_ready_q, in_ready_d;

  assign in_entry = build_entry(in_addr, in_data, store_op_e'(in_op));

`ifdef STORE_ALIGN_EXC_EN
  logic bad_align;
  logic adr_exc_q, adr_exc_d;

  assign bad_align = misaligned(in_addr[1:0], store_op_e'(in_op));
  assign push      = in_valid && in_ready_q && !bad_align;

  always_comb adr_exc_d = in_valid && in_ready_q && bad_align;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) adr_exc_q <= 1'b0;
    else       adr_exc_q <= adr_exc_d;
  end

  assign adr_exc = adr_exc_q;
`else
  assign push    = in_valid && in_ready_q;
  assign adr_exc = 1'b0;
`endif

  assign pop = (state_q == ST_REQ) && mem_ack;

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .wdata      (in_entry),
    .pop        (pop),
    .rdata      (head),
    .count      (count),
    .count_next (count_next)
  );

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    in_ready_d = (count_next != FULL);
    case (state_q)
      ST_IDLE: if (count != '0) state_d = ST_REQ;
      ST_REQ:  if (mem_ack && count_next == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignment so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Memory port shows the head entry only while requesting; zero otherwise.
  always_comb begin
    mem_req   = (state_q == ST_REQ);
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (state_q == ST_REQ) begin
      mem_addr  = head.addr;
      mem_be    = head.be;
      mem_wdata = head.data;
    end
  end

  assign in_ready = in_ready_q;
  assign empty    = (count == '0) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_store_unit.sv
// Directed self-checking bench for store_unit (DEPTH = 2); follows the
// STORE_ALIGN_EXC_EN setting it is compiled with.
module tb_store_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_op = '0;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        empty;
  logic        adr_exc;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [65:0] writes [$];

  store_unit #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_op     (in_op),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .empty     (empty),
    .adr_exc   (adr_exc)
  );

  always #5 clk = ~clk;

  // Memory-side monitor: every accepted write, as {addr, be, data}.
  always @(posedge clk) begin
    if (!reset && mem_req && mem_ack) writes.push_back({mem_addr, mem_be, mem_wdata});
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int max_cycles, input string name);
    int n = 0;
    while (empty !== 1'b1 && n < max_cycles) begin
      cycle();
      n++;
    end
    tests_run++;
    if (empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s drain timeout: empty=%b after %0d cycles, want 1", name, empty, n);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    tests_run++; if (mem_req !== 1'b0)   begin tests_failed++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
    tests_run++; if (mem_addr !== '0)    begin tests_failed++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    tests_run++; if (mem_be !== 4'b0000) begin tests_failed++; $display("FAIL rst_mem_be got %b want 0000", mem_be); end
    tests_run++; if (mem_wdata !== '0)   begin tests_failed++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
    tests_run++; if (adr_exc !== 1'b0)   begin tests_failed++; $display("FAIL rst_adr_exc got %b want 0", adr_exc); end
    tests_run++; if (empty !== 1'b1)     begin tests_failed++; $display("FAIL rst_empty got %b want 1", empty); end
    tests_run++; if (in_ready !== 1'b1)  begin tests_failed++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_byte();
    writes.delete();
    in_valid = 1'b1; in_addr = 32'h0000_1003; in_data = 32'h0000_00A5; in_op = 2'd1;
    cycle();
    in_valid = 1'b0;
    tests_run++; if (empty !== 1'b0) begin tests_failed++; $display("FAIL sb_empty_after_push got %b want 0", empty); end
    cycle();
    tests_run++; if (mem_req !== 1'b1)          begin tests_failed++; $display("FAIL sb_mem_req got %b want 1", mem_req); end
    tests_run++; if (mem_addr !== 30'h400)      begin tests_failed++; $display("FAIL sb_mem_addr got %h want 0000400", mem_addr); end
    tests_run++; if (mem_be !== 4'b1000)        begin tests_failed++; $display("FAIL sb_mem_be got %b want 1000", mem_be); end
    tests_run++; if (mem_wdata !== 32'hA5A5A5A5) begin tests_failed++; $display("FAIL sb_mem_wdata got %h want a5a5a5a5", mem_wdata); end
    cycle();
    tests_run++; if (mem_req !== 1'b1 || mem_addr !== 30'h400) begin
      tests_failed++; $display("FAIL sb_hold req=%b addr=%h want 1/0000400", mem_req, mem_addr);
    end
    mem_ack = 1'b1;
    cycle();
    mem_ack = 1'b0;
    tests_run++; if (mem_req !== 1'b0 || mem_be !== 4'b0000 || empty !== 1'b1) begin
      tests_failed++; $display("FAIL sb_done req=%b be=%b empty=%b want 0/0000/1", mem_req, mem_be, empty);
    end
    tests_run++; if (writes.size() != 1 || writes[0] !== {30'h400, 4'b1000, 32'hA5A5A5A5}) begin
      tests_failed++; $display("FAIL sb_write count=%0d want one write of 400/1000/a5a5a5a5", writes.size());
    end
  endtask

  task automatic one_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] op,
                           input logic [65:0] exp, input string name);
    writes.delete();
    in_valid = 1'b1; in_addr = a; in_data = d; in_op = op;
    cycle();
    in_valid = 1'b0;
    cycle();
    tests_run++; if (mem_req !== 1'b1 || {mem_addr, mem_be, mem_wdata} !== exp) begin
      tests_failed++;
      $display("FAIL %s got req=%b addr=%h be=%b data=%h want addr=%h be=%b data=%h", name,
               mem_req, mem_addr, mem_be, mem_wdata, exp[65:36], exp[35:32], exp[31:0]);
    end
    mem_ack = 1'b1;
    cycle();
    mem_ack = 1'b0;
    tests_run++; if (writes.size() != 1 || writes[0] !== exp || empty !== 1'b1) begin
      tests_failed++; $display("FAIL %s_drain writes=%0d empty=%b want 1/1", name, writes.size(), empty);
    end
  endtask

  task automatic test_lanes();
    one_store(32'h0000_2002, 32'h1234_BEEF, 2'd2, {30'h800, 4'b1100, 32'hBEEF_BEEF}, "sh_hi");
    one_store(32'h0000_2000, 32'h1234_BEEF, 2'd2, {30'h800, 4'b0011, 32'hBEEF_BEEF}, "sh_lo");
    one_store(32'h0000_1000, 32'h0000_003C, 2'd1, {30'h400, 4'b0001, 32'h3C3C_3C3C}, "sb_l0");
    one_store(32'h0000_1001, 32'hFFFF_FF5A, 2'd1, {30'h400, 4'b0010, 32'h5A5A_5A5A}, "sb_l1");
    one_store(32'h0000_3000, 32'hDEAD_BEEF, 2'd0, {30'hC00, 4'b1111, 32'hDEAD_BEEF}, "sw");
    one_store(32'h0000_3004, 32'hCAFE_F00D, 2'd3, {30'hC01, 4'b1111, 32'hCAFE_F00D}, "sw_op3");
  endtask

  task automatic test_idle_ack();
    writes.delete();
    mem_ack = 1'b1;
    cycle();
    cycle();
    mem_ack = 1'b0;
    tests_run++; if (mem_req !== 1'b0 || mem_be !== 4'b0000 || empty !== 1'b1 || writes.size() != 0) begin
      tests_failed++; $display("FAIL idle_ack req=%b be=%b empty=%b writes=%0d want 0/0000/1/0",
                               mem_req, mem_be, empty, writes.size());
    end
  endtask

  task automatic test_misaligned();
    writes.delete();
    in_valid = 1'b1; in_addr = 32'h0000_2001; in_data = 32'h0000_5678; in_op = 2'd2;
    cycle();
    in_valid = 1'b0;
`ifdef STORE_ALIGN_EXC_EN
    tests_run++; if (adr_exc !== 1'b1 || empty !== 1'b1) begin
      tests_failed++; $display("FAIL mis_pulse adr_exc=%b empty=%b want 1/1", adr_exc, empty);
    end
    cycle();
    tests_run++; if (adr_exc !== 1'b0 || empty !== 1'b1 || mem_req !== 1'b0) begin
      tests_failed++; $display("FAIL mis_after adr_exc=%b empty=%b req=%b want 0/1/0", adr_exc, empty, mem_req);
    end
`else
    tests_run++; if (adr_exc !== 1'b0) begin tests_failed++; $display("FAIL mis_adr_exc got %b want 0", adr_exc); end
    cycle();
    tests_run++; if (mem_req !== 1'b1 || {mem_addr, mem_be, mem_wdata} !== {30'h800, 4'b0011, 32'h5678_5678}) begin
      tests_failed++; $display("FAIL mis_push req=%b addr=%h be=%b data=%h want 1/0000800/0011/56785678",
                               mem_req, mem_addr, mem_be, mem_wdata);
    end
    mem_ack = 1'b1;
    cycle();
    mem_ack = 1'b0;
`endif
    wait_empty(4, "mis");
  endtask

  task automatic test_full();
    writes.delete();
    mem_ack = 1'b0;
    in_valid = 1'b1; in_op = 2'd0; in_addr = 32'h0000_0100; in_data = 32'h1111_1111;
    cycle();
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL full_rdy1 got %b want 1", in_ready); end
    in_addr = 32'h0000_0104; in_data = 32'h2222_2222;
    cycle();
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_rdy2 got %b want 0", in_ready); end
    tests_run++; if (mem_req !== 1'b1 || mem_addr !== 30'h40) begin
      tests_failed++; $display("FAIL full_head req=%b addr=%h want 1/0000040", mem_req, mem_addr);
    end
    in_addr = 32'h0000_0108; in_data = 32'h3333_3333;
    cycle();
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_stall got %b want 0", in_ready); end
    mem_ack = 1'b1;
    cycle();
    mem_ack = 1'b0;
    tests_run++; if (in_ready !== 1'b1 || mem_addr !== 30'h41) begin
      tests_failed++; $display("FAIL full_pop rdy=%b addr=%h want 1/0000041", in_ready, mem_addr);
    end
    cycle();
    in_valid = 1'b0;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_third got %b want 0", in_ready); end
    mem_ack = 1'b1;
    wait_empty(10, "full");
    mem_ack = 1'b0;
    tests_run++; if (writes.size() != 3
                     || writes[0] !== {30'h40, 4'b1111, 32'h1111_1111}
                     || writes[1] !== {30'h41, 4'b1111, 32'h2222_2222}
                     || writes[2] !== {30'h42, 4'b1111, 32'h3333_3333}) begin
      tests_failed++; $display("FAIL full_order writes=%0d want 3 in push order", writes.size());
    end
  endtask

  task automatic test_back_to_back();
    int   idx = 0;
    int   cyc = 0;
    logic rdy;
    logic ok = 1'b1;
    writes.delete();
    mem_ack = 1'b1;
    in_valid = 1'b1; in_op = 2'd0;
    in_addr = 32'h0000_4000; in_data = 32'hB000_0000;
    while (idx < 8 && cyc < 40) begin
      rdy = in_ready;
      cycle();
      cyc++;
      if (rdy) idx++;
      in_addr = 32'h0000_4000 + 32'(4 * idx);
      in_data = 32'hB000_0000 + 32'(idx);
      if (idx >= 8) in_valid = 1'b0;
      if (cyc >= 3) begin
        tests_run++;
        if (in_ready !== 1'b1 || mem_req !== 1'b1 || writes.size() != cyc - 2) begin
          tests_failed++;
          $display("FAIL b2b_cycle%0d rdy=%b req=%b writes=%0d want 1/1/%0d",
                   cyc, in_ready, mem_req, writes.size(), cyc - 2);
        end
      end
    end
    in_valid = 1'b0;
    wait_empty(10, "b2b");
    mem_ack = 1'b0;
    if (writes.size() != 8) ok = 1'b0;
    for (int i = 0; i < 8 && i < writes.size(); i++)
      if (writes[i] !== {30'h1000 + 30'(i), 4'b1111, 32'hB000_0000 + 32'(i)}) ok = 1'b0;
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL b2b_order writes=%0d want 8 in push order", writes.size()); end
  endtask

  task automatic test_reset_mid();
    writes.delete();
    mem_ack = 1'b0;
    in_valid = 1'b1; in_op = 2'd0; in_addr = 32'h0000_0500; in_data = 32'h0000_0001;
    cycle();
    in_addr = 32'h0000_0504; in_data = 32'h0000_0002;
    cycle();
    in_valid = 1'b0;
    tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL rmid_req_before got %b want 1", mem_req); end
    #2 reset = 1'b1;
    #1;
    tests_run++; if (mem_req !== 1'b0 || mem_be !== 4'b0000 || empty !== 1'b1 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL rmid_immediate req=%b be=%b empty=%b rdy=%b want 0/0000/1/1",
                               mem_req, mem_be, empty, in_ready);
    end
    cycle();
    cycle();
    reset = 1'b0;
    mem_ack = 1'b1;
    repeat (4) cycle();
    mem_ack = 1'b0;
    tests_run++; if (writes.size() != 0 || mem_req !== 1'b0 || empty !== 1'b1) begin
      tests_failed++; $display("FAIL rmid_after writes=%0d req=%b empty=%b want 0/0/1", writes.size(), mem_req, empty);
    end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_lanes();
    test_idle_ack();
    test_misaligned();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
